load_store_unit: RTL and testbench

Memory-access stage between execute and writeback. Takes a load or store from execute (ALU-computed address, rs2 data, funct3 width), runs one request/ready transaction on the data-memory port, and returns a sign- or zero-extended 32-bit `loaddata` word that writeback selects for loads. Reports misaligned and faulting accesses so the core can suppress the register write and raise an exception. It is a small FSM with registered memory-port outputs and a watchdog.

---
 rtl/load_store_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: one request/ready data-memory transaction per load/store.
// Define LSU_TIMEOUT_EN to abandon requests after TIMEOUT_CYCLES unanswered cycles.
module load_store_unit
`ifdef LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] loaddata,
  output logic        misaligned,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] loaddata_q, loaddata_d;
  logic        misaligned_q, misaligned_d;
  logic        fault_q, fault_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic        op_load;
  logic        illegal;
  logic        unaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // Decode of the operation presented by execute.
  always_comb begin
    op_load = is_load;
    if (op_load) begin
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                (funct3 == 3'b111);
    end else begin
      illegal = (funct3 >= 3'b011);
    end
    unaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    st_wstrb = 4'b1111;
    st_wdata = store_data;
    unique case (funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << addr[1:0];
        st_wdata = {2{store_data[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    unique case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    loaddata_d   = loaddata_q;
    misaligned_d = misaligned_q;
    fault_d      = fault_q;
    f3_d         = f3_q;
    lane_d       = lane_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          misaligned_d = 1'b0;
          fault_d      = 1'b0;
          state_d      = DONE;
          if (is_load || is_store) begin
            if (illegal) begin
              fault_d = 1'b1;
            end else if (unaligned) begin
              misaligned_d = 1'b1;
            end else begin
              state_d     = REQ;
              mem_req_d   = 1'b1;
              mem_we_d    = !op_load;
              mem_addr_d  = {addr[31:2], 2'b00};
              mem_wstrb_d = op_load ? 4'b0000 : st_wstrb;
              mem_wdata_d = op_load ? 32'h0 : st_wdata;
              f3_d        = funct3;
              lane_d      = addr[1:0];
`ifdef LSU_TIMEOUT_EN
              cnt_d       = '0;
`endif
            end
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (!mem_we_q) begin
            loaddata_d = rd_ext;
          end
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
`ifdef LSU_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // Unanswered for the full budget: give up, keep loaddata.
          fault_d     = 1'b1;
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      mem_wdata_q  <= 32'h0;
      loaddata_q   <= 32'h0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      loaddata_q   <= loaddata_d;
      misaligned_q <= misaligned_d;
      fault_q      <= fault_d;
      f3_q         <= f3_d;
      lane_q       <= lane_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign loaddata   = loaddata_q;
  assign misaligned = misaligned_q;
  assign fault      = fault_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; hand-computed expectations.
// Build with LSU_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, misaligned, fault;
  logic [31:0] loaddata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  int          lat, req_n, unstable;
  logic        saw_done;
  logic [31:0] c_addr, c_wdata;
  logic        c_we;
  logic [3:0]  c_wstrb;

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
  load_store_unit dut (
`endif
    .clk(clk), .rst(rst), .start(start),
    .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .loaddata(loaddata),
    .misaligned(misaligned), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, answer its request after `waits` unready cycles.
  task automatic run_op(input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int waits);
    is_load = ld; is_store = st; funct3 = f3;
    addr = a; store_data = sd; start = 1'b1;
    req_n = 0; unstable = 0; saw_done = 1'b0;
    c_addr = 0; c_we = 0; c_wstrb = 0; c_wdata = 0;
    step();
    start = 1'b0; lat = 1; mem_rdata = rd;
    while (!done && lat < 60) begin
      if (mem_req) begin
        if (req_n == 0) begin
          c_addr = mem_addr; c_we = mem_we;
          c_wstrb = mem_wstrb; c_wdata = mem_wdata;
        end else if (mem_addr !== c_addr || mem_we !== c_we ||
                     mem_wstrb !== c_wstrb || mem_wdata !== c_wdata) begin
          unstable++;
        end
        mem_ready = (req_n == waits);
        req_n++;
      end
      step();
      mem_ready = 1'b0;
      lat++;
    end
    saw_done = done;
    step();
  endtask

  task automatic expect_op(input string tag, input int e_lat,
                           input int e_req, input logic e_mis,
                           input logic e_flt);
    check({tag, "_done"}, 32'(saw_done), 32'd1);
    check({tag, "_lat"}, lat, e_lat);
    check({tag, "_reqcyc"}, req_n, e_req);
    check({tag, "_stable"}, unstable, 0);
    check({tag, "_mis"}, 32'(misaligned), 32'(e_mis));
    check({tag, "_flt"}, 32'(fault), 32'(e_flt));
    check({tag, "_idle"}, {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ld", loaddata, 0);
    check("rst_flags", {30'h0, misaligned, fault}, 0);
    check("rst_req", {30'h0, mem_req, mem_we}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wstrb", 32'(mem_wstrb), 0);
    check("rst_wdata", mem_wdata, 0);

    run_op(1, 0, 3'b000, 32'h1003, 0, 32'h80FF_1122, 0);
    expect_op("lb", 2, 1, 0, 0);
    check("lb_data", loaddata, 32'hFFFF_FF80);
    check("lb_maddr", c_addr, 32'h1000);
    check("lb_we", {27'h0, c_wstrb, c_we}, 0);

    run_op(1, 0, 3'b101, 32'h2002, 0, 32'hBEEF_0000, 3);
    expect_op("lhu", 5, 4, 0, 0);
    check("lhu_data", loaddata, 32'h0000_BEEF);
    check("lhu_maddr", c_addr, 32'h2000);

    run_op(0, 1, 3'b001, 32'h10, 32'h1234_ABCD, 0, 0);
    expect_op("sh", 2, 1, 0, 0);
    check("sh_we", 32'(c_we), 1);
    check("sh_wstrb", 32'(c_wstrb), 32'h3);
    check("sh_wdata", c_wdata, 32'hABCD_ABCD);
    check("sh_ldkeep", loaddata, 32'h0000_BEEF);

    run_op(0, 1, 3'b000, 32'h13, 32'h1234_ABCD, 0, 1);
    expect_op("sb", 3, 2, 0, 0);
    check("sb_wstrb", 32'(c_wstrb), 32'h8);
    check("sb_wdata", c_wdata, 32'hCDCD_CDCD);
    check("sb_maddr", c_addr, 32'h10);

    run_op(0, 1, 3'b010, 32'h44, 32'h0BAD_F00D, 0, 0);
    expect_op("sw", 2, 1, 0, 0);
    check("sw_wstrb", 32'(c_wstrb), 32'hF);
    check("sw_wdata", c_wdata, 32'h0BAD_F00D);

    run_op(1, 0, 3'b010, 32'h6, 0, 32'h1111_1111, 0);
    expect_op("lw_mis", 1, 0, 1, 0);
    check("lw_mis_ld", loaddata, 32'h0000_BEEF);

    run_op(1, 0, 3'b011, 32'h0, 0, 32'h1111_1111, 0);
    expect_op("ld_ill", 1, 0, 0, 1);

    run_op(0, 1, 3'b011, 32'h0, 0, 0, 0);
    expect_op("st_ill", 1, 0, 0, 1);

    run_op(0, 1, 3'b001, 32'h11, 32'h5555, 0, 0);
    expect_op("sh_mis", 1, 0, 1, 0);

    run_op(1, 0, 3'b001, 32'h102, 0, 32'h8001_7FFF, 1);
    expect_op("lh", 3, 2, 0, 0);
    check("lh_data", loaddata, 32'hFFFF_8001);

    run_op(1, 0, 3'b010, 32'h200, 0, 32'hDEAD_BEEF, 0);
    expect_op("lw", 2, 1, 0, 0);
    check("lw_data", loaddata, 32'hDEAD_BEEF);

    run_op(0, 0, 3'b010, 32'h3, 0, 32'h1234_5678, 0);
    expect_op("nop", 1, 0, 0, 0);
    check("nop_ld", loaddata, 32'hDEAD_BEEF);

    run_op(1, 1, 3'b100, 32'h1, 32'hFFFF_FFFF, 32'h0000_F000, 0);
    expect_op("both", 2, 1, 0, 0);
    check("both_data", loaddata, 32'h0000_00F0);
    check("both_we", 32'(c_we), 0);

    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ready = 1'b0;
    check("idle_rdy", {30'h0, busy, done}, 0);
    check("idle_rdy_ld", loaddata, 32'h0000_00F0);

`ifdef LSU_TIMEOUT_EN
    run_op(1, 0, 3'b010, 32'h400, 0, 32'h7777_7777, 100);
    expect_op("tmo", 5, 4, 0, 1);
    check("tmo_ld", loaddata, 32'h0000_00F0);
    run_op(1, 0, 3'b010, 32'h400, 0, 32'h7777_7777, 3);
    expect_op("tmo_edge", 5, 4, 0, 0);
    check("tmo_edge_ld", loaddata, 32'h7777_7777);
`else
    run_op(1, 0, 3'b010, 32'h400, 0, 32'h7777_7777, 12);
    expect_op("longwait", 14, 13, 0, 0);
    check("longwait_ld", loaddata, 32'h7777_7777);
`endif

    is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h300; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("rst2_req", 32'(mem_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_busy", 32'(busy), 0);
    check("rst2_done", 32'(done), 0);
    check("rst2_req0", {30'h0, mem_req, mem_we}, 0);
    check("rst2_ld", loaddata, 0);
    check("rst2_addr", mem_addr, 0);
    step();
    run_op(1, 0, 3'b000, 32'h1003, 0, 32'h80FF_1122, 0);
    expect_op("post_rst", 2, 1, 0, 0);
    check("post_rst_ld", loaddata, 32'hFFFF_FF80);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
